// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: FSM states,
// instruction field encodings, datapath select codes, halt causes, the
// control-vector layout and an instruction classifier.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // IR[5:0] function codes for R-type
    localparam logic [5:0] FN_NOP     = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SLT     = 6'b101010;

    // ALU operation codes (share the R-type funct numbering)
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SLT = 6'b101010;
    localparam logic [5:0] ALU_NOP = 6'b101100;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RS     = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_SYSCALL = 2'b01,
        CAUSE_ILLEGAL = 2'b10,
        CAUSE_BUS     = 2'b11
    } cause_t;

    // Instruction classes the sequencer distinguishes
    typedef enum logic [3:0] {
        IC_ALU,
        IC_XORI,
        IC_LW,
        IC_SW,
        IC_BNE,
        IC_J,
        IC_JAL,
        IC_JR,
        IC_NOP,
        IC_SYSCALL,
        IC_ILLEGAL
    } iclass_t;

    // Datapath control vector produced by the output decoder
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [5:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       wri_data_sel;
        logic       halted;
    } ctrl_t;

    // Map the IR opcode/funct fields onto an instruction class
    function automatic iclass_t classify(input logic [5:0] opcode, input logic [5:0] funct);
        iclass_t ic;
        ic = IC_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_NOP:                 ic = IC_NOP;
                    FN_JR:                  ic = IC_JR;
                    FN_SYSCALL:             ic = IC_SYSCALL;
                    FN_ADD, FN_SUB, FN_SLT: ic = IC_ALU;
                    default:                ic = IC_ILLEGAL;
                endcase
            end
            OP_J:    ic = IC_J;
            OP_JAL:  ic = IC_JAL;
            OP_BNE:  ic = IC_BNE;
            OP_XORI: ic = IC_XORI;
            OP_LW:   ic = IC_LW;
            OP_SW:   ic = IC_SW;
            default: ic = IC_ILLEGAL;
        endcase
        return ic;
    endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// Combinational decode of FSM state and instruction class into the datapath
// control vector. Only FETCH looks at mem_ready (IR/PC load on acceptance).
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t     state,
    input  iclass_t    iclass,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    // Control outputs per state; everything not driven below stays idle
    always_comb begin
        // NOTE: defaulting the whole vector first keeps every path assigned, so no latch is inferred.
        ctrl        = '0;
        ctrl.alu_op = ALU_NOP;
        case (state)
            ST_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                end
            end
            ST_DECODE: begin
                // ALU precomputes the branch target while the class resolves
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_BRANCH;
                ctrl.alu_op    = ALU_ADD;
                case (iclass)
                    IC_J: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_JUMP;
                    end
                    IC_JAL: begin
                        ctrl.pc_write     = 1'b1;
                        ctrl.pc_src       = PC_SRC_JUMP;
                        ctrl.reg_write    = 1'b1;
                        ctrl.reg_dst      = REGDST_RA;
                        ctrl.wri_data_sel = 1'b0;
                    end
                    IC_JR: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_RS;
                    end
                    default: ;
                endcase
            end
            ST_EXEC: begin
                // Every EXEC form operates on rs as operand A
                ctrl.alu_src_a = 1'b1;
                case (iclass)
                    IC_ALU: begin
                        ctrl.alu_src_b = SRCB_RT;
                        ctrl.alu_op    = funct;
                    end
                    IC_XORI: begin
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.imm_zext  = 1'b1;
                        ctrl.alu_op    = ALU_XOR;
                    end
                    IC_LW, IC_SW: begin
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALU_ADD;
                    end
                    IC_BNE: begin
                        ctrl.alu_src_b = SRCB_RT;
                        ctrl.alu_op    = ALU_SUB;
                        ctrl.branch_ne = 1'b1;
                        ctrl.pc_src    = PC_SRC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.mem_we  = (iclass == IC_SW);
            end
            ST_WB: begin
                ctrl.reg_write    = 1'b1;
                ctrl.wri_data_sel = 1'b1;
                ctrl.reg_dst      = (iclass == IC_ALU) ? REGDST_RD : REGDST_RT;
                ctrl.mem_to_reg   = (iclass == IC_LW);
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes
// with a variable-latency memory, halts on SYSCALL, illegal opcodes or a
// memory timeout, and counts retired instructions.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int ALUOP_W = 6,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               branch_ne,
    output logic [1:0]         pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               imm_zext,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic [1:0]         reg_dst,
    output logic               mem_to_reg,
    output logic               wri_data_sel,
    output logic               halted,
    output logic [1:0]         cause,
    output logic [CNT_W-1:0]   instret
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state, state_next;
    cause_t            cause_q, cause_next;
    logic [WAIT_W-1:0] wait_cnt;
    iclass_t           iclass;
    ctrl_t             ctrl;
    logic              timeout_hit;
    logic              waiting;
    logic              retire;

    assign iclass      = classify(opcode, funct);
    assign waiting     = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
    assign timeout_hit = (TIMEOUT > 0) && !mem_ready && (wait_cnt == WAIT_W'(TIMEOUT));
    // Every return to FETCH completes an instruction, except the start-up hop
    assign retire      = (state_next == ST_FETCH) && (state != ST_FETCH) && (state != ST_IDLE);

    // State register; async reset makes mem_req drop without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and halt-cause selection
    always_comb begin
        state_next = state;
        cause_next = cause_q;
        case (state)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_BUS;
                end
            end
            ST_DECODE: begin
                case (iclass)
                    IC_J, IC_JAL, IC_JR, IC_NOP:             state_next = ST_FETCH;
                    IC_LW, IC_SW, IC_BNE, IC_XORI, IC_ALU:   state_next = ST_EXEC;
                    IC_SYSCALL: begin
                        state_next = ST_HALT;
                        cause_next = CAUSE_SYSCALL;
                    end
                    default: begin
                        state_next = ST_HALT;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC: begin
                case (iclass)
                    IC_ALU, IC_XORI: state_next = ST_WB;
                    IC_LW, IC_SW:    state_next = ST_MEM;
                    IC_BNE:          state_next = ST_FETCH;
                    default: begin
                        // IR changed under us after DECODE; treat as illegal
                        state_next = ST_HALT;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_next = (iclass == IC_LW) ? ST_WB : ST_FETCH;
                end else if (timeout_hit) begin
                    state_next = ST_HALT;
                    cause_next = CAUSE_BUS;
                end
            end
            ST_WB:   state_next = ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // Memory wait counter: cycles spent stalled in the current FETCH/MEM visit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wait_cnt <= '0;
        else if (state_next != state)    wait_cnt <= '0;
        else if (waiting && TIMEOUT > 0) wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Halt cause register, latched on entry to HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cause_q <= CAUSE_NONE;
        else        cause_q <= cause_next;
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      instret <= '0;
        else if (retire) instret <= instret + CNT_W'(1);
    end

    // Output decode of registered state
    mc_output_decode u_decode (
        .state     (state),
        .iclass    (iclass),
        .funct     (funct),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign iord         = ctrl.iord;
    assign ir_write     = ctrl.ir_write;
    assign pc_write     = ctrl.pc_write;
    assign branch_ne    = ctrl.branch_ne;
    assign pc_src       = ctrl.pc_src;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign imm_zext     = ctrl.imm_zext;
    assign alu_op       = ALUOP_W'(ctrl.alu_op);
    assign reg_write    = ctrl.reg_write;
    assign reg_dst      = ctrl.reg_dst;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign wri_data_sel = ctrl.wri_data_sel;
    assign halted       = ctrl.halted;
    assign cause        = cause_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instruction table,
// hand-written corner sequences (timeouts, traps, async reset, counter wrap)
// and a randomized run against an instruction-plan reference model.
module tb_multicycle_control;

    localparam logic [5:0] T_RTYPE = 6'b000000, T_J = 6'b000010, T_JAL = 6'b000011;
    localparam logic [5:0] T_BNE = 6'b000101, T_XORI = 6'b001110, T_LW = 6'b100011, T_SW = 6'b101011;
    localparam logic [5:0] F_NOP = 6'b000000, F_JR = 6'b001000, F_SYS = 6'b001100;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010;
    localparam logic [5:0] A_ADD = 6'b100000, A_SUB = 6'b100010, A_XOR = 6'b100110, A_NOP = 6'b101100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, branch_ne;
    logic [1:0] pc_src, alu_src_b, reg_dst, cause;
    logic       alu_src_a, imm_zext, reg_write, mem_to_reg, wri_data_sel, halted;
    logic [5:0] alu_op;
    logic [3:0] instret;

    multicycle_control #(.ALUOP_W(6), .TIMEOUT(15), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .branch_ne(branch_ne), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .wri_data_sel(wri_data_sel),
        .halted(halted), .cause(cause), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_write, pc_write, branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [5:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg, wri_data_sel, halted;
        logic [1:0] cause;
        logic [3:0] instret;
    } obs_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        int         mem_delay;
        int         exp_len;
        logic [5:0] exec_alu;
        logic       last_reg_write;
        logic [1:0] last_reg_dst;
        logic       last_mem_to_reg;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    obs_t trace[$];

    // Reference model: phase letter plus the remaining phase plan of the instruction
    byte   m_ph = "I";
    string m_plan = "";
    int    m_wait = 0;
    int    m_instret = 0;
    int    m_cause = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord; o.ir_write = ir_write;
        o.pc_write = pc_write; o.branch_ne = branch_ne; o.pc_src = pc_src;
        o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.imm_zext = imm_zext;
        o.alu_op = alu_op; o.reg_write = reg_write; o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.wri_data_sel = wri_data_sel; o.halted = halted;
        o.cause = cause; o.instret = instret;
        return o;
    endfunction

    // Which phases follow DECODE; a digit means a trap with that cause
    function automatic string plan_for(input logic [5:0] op, input logic [5:0] fn);
        if (op == T_RTYPE) begin
            if (fn == F_NOP || fn == F_JR) return "";
            if (fn == F_SYS) return "1";
            if (fn == F_ADD || fn == F_SUB || fn == F_SLT) return "XW";
            return "2";
        end
        if (op == T_J || op == T_JAL) return "";
        if (op == T_BNE) return "X";
        if (op == T_XORI) return "XW";
        if (op == T_LW) return "XMW";
        if (op == T_SW) return "XM";
        return "2";
    endfunction

    function automatic obs_t expect_out(input byte ph, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy);
        obs_t o;
        o = '0;
        o.alu_op = A_NOP;
        if (ph == "F") begin
            o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_op = A_ADD;
            o.ir_write = rdy; o.pc_write = rdy;
        end else if (ph == "D") begin
            o.alu_src_b = 2'b11; o.alu_op = A_ADD;
            if (op == T_J || op == T_JAL) begin o.pc_write = 1; o.pc_src = 2'b10; end
            if (op == T_JAL) begin o.reg_write = 1; o.reg_dst = 2'b10; end
            if (op == T_RTYPE && fn == F_JR) begin o.pc_write = 1; o.pc_src = 2'b11; end
        end else if (ph == "X") begin
            o.alu_src_a = 1;
            if (op == T_RTYPE) o.alu_op = fn;
            if (op == T_XORI) begin o.alu_src_b = 2'b10; o.imm_zext = 1; o.alu_op = A_XOR; end
            if (op == T_LW || op == T_SW) begin o.alu_src_b = 2'b10; o.alu_op = A_ADD; end
            if (op == T_BNE) begin o.alu_op = A_SUB; o.branch_ne = 1; o.pc_src = 2'b01; end
        end else if (ph == "M") begin
            o.mem_req = 1; o.iord = 1; o.mem_we = (op == T_SW);
        end else if (ph == "W") begin
            o.reg_write = 1; o.wri_data_sel = 1;
            o.reg_dst = (op == T_RTYPE) ? 2'b01 : 2'b00;
            o.mem_to_reg = (op == T_LW);
        end else if (ph == "H") begin
            o.halted = 1;
        end
        return o;
    endfunction

    task automatic advance();
        m_wait = 0;
        if (m_plan.len() == 0) begin
            m_ph = "F";
            m_instret = (m_instret + 1) % 16;
        end else if (m_plan[0] == "1" || m_plan[0] == "2") begin
            m_ph = "H";
            m_cause = m_plan[0] - "0";
            m_plan = "";
        end else begin
            m_ph = m_plan[0];
            m_plan = m_plan.substr(1, m_plan.len() - 1);
        end
    endtask

    task automatic model_step();
        case (m_ph)
            "I": begin m_ph = "F"; m_wait = 0; end
            "F", "M": begin
                if (mem_ready) begin
                    if (m_ph == "F") begin m_ph = "D"; m_wait = 0; end
                    else advance();
                end else if (m_wait == 15) begin
                    m_ph = "H"; m_cause = 3;
                end else begin
                    m_wait++;
                end
            end
            "D": begin m_plan = plan_for(opcode, funct); advance(); end
            "X", "W": advance();
            default: ;
        endcase
    endtask

    // One clock: compare against the model between edges, then cross a posedge
    task automatic tick();
        obs_t act, exp;
        #2;
        act = sample();
        exp = expect_out(m_ph, opcode, funct, mem_ready);
        exp.cause = 2'(m_cause);
        exp.instret = 4'(m_instret);
        check($sformatf("cycle_%c", m_ph), 64'(act), 64'(exp));
        trace.push_back(act);
        model_step();
        @(negedge clk);
    endtask

    // Reset, check the idle vector, and leave the DUT at the start of FETCH
    task automatic do_reset();
        obs_t rexp;
        rexp = '0;
        rexp.alu_op = A_NOP;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", 64'(sample()), 64'(rexp));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ph = "I"; m_plan = ""; m_wait = 0; m_instret = 0; m_cause = 0;
        tick();
    endtask

    // Run one instruction from FETCH until the DUT is back in FETCH or halted
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mem_delay);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        opcode = op; funct = fn; trace.delete();
        mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 40 && !done; k++) begin
            if ((mem_req && !iord) || halted) begin
                done = 1;
            end else begin
                mem_ready = !(mem_req && iord && waited < mem_delay);
                if (!mem_ready) waited++;
                tick();
            end
        end
        check("run_bound", 64'(done), 64'(1));
    endtask

    vec_t vecs[10];

    initial begin
        int mem_cycles, base;
        obs_t last;

        vecs[0] = '{"add",  T_RTYPE, F_ADD, 0, 4, A_ADD, 1'b1, 2'b01, 1'b0};
        vecs[1] = '{"sub",  T_RTYPE, F_SUB, 0, 4, A_SUB, 1'b1, 2'b01, 1'b0};
        vecs[2] = '{"slt",  T_RTYPE, F_SLT, 0, 4, F_SLT, 1'b1, 2'b01, 1'b0};
        vecs[3] = '{"xori", T_XORI,  6'h15, 0, 4, A_XOR, 1'b1, 2'b00, 1'b0};
        vecs[4] = '{"lw",   T_LW,    6'h04, 3, 8, A_ADD, 1'b1, 2'b00, 1'b1};
        vecs[5] = '{"sw",   T_SW,    6'h08, 0, 4, A_ADD, 1'b0, 2'b00, 1'b0};
        vecs[6] = '{"bne",  T_BNE,   6'h3c, 0, 3, A_SUB, 1'b0, 2'b00, 1'b0};
        vecs[7] = '{"jal",  T_JAL,   6'h10, 0, 2, A_ADD, 1'b1, 2'b10, 1'b0};
        vecs[8] = '{"j",    T_J,     6'h20, 0, 2, A_ADD, 1'b0, 2'b00, 1'b0};
        vecs[9] = '{"jr",   T_RTYPE, F_JR,  0, 2, A_ADD, 1'b0, 2'b00, 1'b0};

        @(negedge clk);
        do_reset();

        // Table: phase count, EXEC ALU op, final-phase register controls, retire count
        for (int i = 0; i < 10; i++) begin
            base = m_instret;
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].mem_delay);
            check({vecs[i].name, "_len"}, 64'(trace.size()), 64'(vecs[i].exp_len));
            last = trace[trace.size() - 1];
            if (trace.size() > 2)
                check({vecs[i].name, "_exec_alu"}, 64'(trace[2].alu_op), 64'(vecs[i].exec_alu));
            check({vecs[i].name, "_reg_write"}, 64'(last.reg_write), 64'(vecs[i].last_reg_write));
            check({vecs[i].name, "_reg_dst"}, 64'(last.reg_dst), 64'(vecs[i].last_reg_dst));
            check({vecs[i].name, "_mem_to_reg"}, 64'(last.mem_to_reg), 64'(vecs[i].last_mem_to_reg));
            check({vecs[i].name, "_instret"}, 64'(instret), 64'((base + 1) % 16));
        end

        // LW with a 3-cycle memory stall holds mem_req with iord=1 for 4 cycles
        do_reset();
        run_instr(T_LW, 6'h00, 3);
        mem_cycles = 0;
        foreach (trace[k]) if (trace[k].mem_req && trace[k].iord) mem_cycles++;
        check("lw_mem_req_cycles", 64'(mem_cycles), 64'(4));
        check("lw_instret", 64'(instret), 64'(1));

        // SW writes in MEM and never asserts reg_write
        run_instr(T_SW, 6'h00, 1);
        check("sw_mem_we", 64'(trace[trace.size() - 1].mem_we), 64'(1));
        mem_cycles = 0;
        foreach (trace[k]) if (trace[k].reg_write) mem_cycles++;
        check("sw_no_reg_write", 64'(mem_cycles), 64'(0));

        // BNE asserts branch_ne with pc_src=ALUOut in EXEC
        run_instr(T_BNE, 6'h00, 0);
        check("bne_branch_ne", 64'(trace[2].branch_ne), 64'(1));
        check("bne_pc_src", 64'(trace[2].pc_src), 64'(2'b01));

        // JAL links through PC in DECODE
        run_instr(T_JAL, 6'h00, 0);
        check("jal_pc_write", 64'(trace[1].pc_write), 64'(1));
        check("jal_pc_src", 64'(trace[1].pc_src), 64'(2'b10));
        check("jal_wri_data_sel", 64'(trace[1].wri_data_sel), 64'(0));

        // FETCH timeout: 15 stalled cycles still waiting, the 16th halts with bus error
        do_reset();
        mem_ready = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        check("fetch_not_yet_halted", 64'(halted), 64'(0));
        tick();
        check("fetch_timeout_halted", 64'(halted), 64'(1));
        check("fetch_timeout_cause", 64'(cause), 64'(2'b11));
        tick();
        check("halt_is_sticky", 64'(halted), 64'(1));

        // MEM timeout on a load
        do_reset();
        run_instr(T_LW, 6'h00, 100);
        check("mem_timeout_len", 64'(trace.size()), 64'(19));
        check("mem_timeout_cause", 64'(cause), 64'(2'b11));

        // Traps
        do_reset();
        run_instr(T_RTYPE, F_SYS, 0);
        check("syscall_cause", 64'(cause), 64'(2'b01));
        check("syscall_halted", 64'(halted), 64'(1));
        do_reset();
        run_instr(6'b111111, 6'h00, 0);
        check("illegal_cause", 64'(cause), 64'(2'b10));

        // Asynchronous reset in the middle of a SW memory access
        do_reset();
        run_instr(T_RTYPE, F_NOP, 0);
        opcode = T_SW; funct = 6'h00;
        mem_ready = 1'b1; tick();
        tick(); tick();
        mem_ready = 1'b0; tick();
        #1;
        check("sw_mem_pending", 64'({mem_req, mem_we}), 64'(2'b11));
        rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 64'({mem_req, mem_we}), 64'(2'b00));
        check("async_rst_instret", 64'(instret), 64'(0));
        @(negedge clk);
        do_reset();

        // Counter wrap with a 4-bit instret
        for (int k = 0; k < 15; k++) run_instr(T_RTYPE, F_NOP, 0);
        check("instret_15", 64'(instret), 64'(15));
        run_instr(T_RTYPE, F_NOP, 0);
        check("instret_wrap", 64'(instret), 64'(0));

        // Randomized instruction stream against the plan model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (m_ph == "H") do_reset();
            if (m_ph == "F") begin
                r = $urandom_range(0, 99);
                if (r < 3) begin
                    opcode = T_RTYPE; funct = F_SYS;
                end else if (r < 7) begin
                    opcode = 6'($urandom); funct = 6'($urandom);
                end else begin
                    case ($urandom_range(0, 10))
                        0: begin opcode = T_RTYPE; funct = F_ADD; end
                        1: begin opcode = T_RTYPE; funct = F_SUB; end
                        2: begin opcode = T_RTYPE; funct = F_SLT; end
                        3: begin opcode = T_RTYPE; funct = F_JR;  end
                        4: begin opcode = T_RTYPE; funct = F_NOP; end
                        5: begin opcode = T_XORI;  funct = 6'($urandom); end
                        6: begin opcode = T_LW;    funct = 6'($urandom); end
                        7: begin opcode = T_SW;    funct = 6'($urandom); end
                        8: begin opcode = T_BNE;   funct = 6'($urandom); end
                        9: begin opcode = T_J;     funct = 6'($urandom); end
                        default: begin opcode = T_JAL; funct = 6'($urandom); end
                    endcase
                end
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
